imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the decode stage of the RV32I/RV64I core.
- Takes the full 32-bit instruction word plus an extension opcode and produces the sign- or zero-extended XLEN-bit immediate.
- Covers I, S, B, U, J, shift-amount and CSR-zimm formats.
- One registered output stage plus a one-entry skid buffer under a valid/ready handshake, so decode can stall without a combinational ready path.
- Flushable on branch mispredict.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
SHAMT_W, 5 if XLEN==32 else 6, shift-amount width (derived; not to be overridden).
TAG_W, 5, width of the sideband tag (rd/pipe ID) carried alongside the immediate.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
flush  in  1  synchronous kill of all buffered entries.
in_valid  in  1  upstream has an instruction.
in_ready  out  1  block can accept; driven directly from a register (no combinational path from out_ready).
instr  in  32  raw instruction word.
ext_op  in  3  format select.
in_tag  in  TAG_W  sideband tag.
out_valid  out  1  imm_out/out_tag valid.
out_ready  in  1  downstream accepts.
imm_out  out  XLEN  extended immediate.
out_tag  out  TAG_W  tag matching imm_out.
out_op  out  3  ext_op of the presented entry.

Behaviour:
- ext_op encoding:
  - 000 NONE → 0.
  - 001 S → sext({instr[31:25],instr[11:7]}).
  - 010 I → sext(instr[31:20]).
  - 011 SHAMT → zext(instr[20+SHAMT_W-1:20]).
  - 100 B → sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - 101 U → sext({instr[31:12],12'b0}); upper bits replicate instr[31] when XLEN=64.
  - 110 J → sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - 111 ZIMM → zext(instr[19:15]).
- Sign extension is always from the format's top bit to XLEN.
- Extension is computed combinationally on input and captured into a register; no extension logic on the output side.
- Storage: main register M (valid mv) drives outputs. Skid register K (valid kv) holds one overflow entry.
- Derived signals:
  - in_ready = !kv (registered flag).
  - accept = in_valid && in_ready.
  - drain = mv && out_ready.
- Per-edge update, priority order:
  1. rst (async) → mv=0, kv=0, in_ready=1; imm_out=0, out_tag=0, out_op=0.
  2. flush → mv=0, kv=0, in_ready=1. Any accept or drain in the same cycle is discarded (flushed input is not captured).
  3. kv && drain → M←K, kv=0.
  4. !kv: accept && (!mv || drain) → M←new, mv=1.
  5. !kv: accept && mv && !drain → K←new, kv=1.
  6. !kv: !accept && drain → mv=0.
- Latency: 1 cycle from accept to out_valid when M is free or draining.
- Order is preserved strictly; there is no reordering between K and M.
- While out_valid && !out_ready, imm_out/out_tag/out_op are held stable.
- Throughput: 1 per cycle with out_ready held high.
- After one stall cycle, in_ready drops the next cycle and returns one cycle after the stall releases.
- Invalid contents: imm_out retains the last value when mv=0. Bench checks it only when out_valid.
- Reset mid-operation: all entries are lost. No output toggles except to the reset values above.

Test Plan:
- Reset, then stream with out_ready=1. Each input must appear 1 cycle later on out_valid, in order:
  - instr=0xFFF00093, op=010 → 0xFFFFFFFF.
  - 0xFE112E23, 001 → 0xFFFFFFFC.
  - 0xFE000CE3, 100 → 0xFFFFFFF8.
  - 0x123450B7, 101 → 0x12345000.
  - 0x001000EF, 110 → 0x00000800.
- SHAMT/ZIMM: 0x01F0D093 op 011 → 0x0000001F (XLEN=32). Same with XLEN=64 and instr[25]=1 → 0x3F. 0x3401D0F3 op 111 → 0x00000003.
- Backpressure: hold out_ready=0 and drive 3 back-to-back valid inputs (tags 1,2,3).
  - Tags 1 and 2 are captured; in_ready=0 from the cycle after tag 2.
  - Tag 3 is held upstream.
  - Release out_ready: tags emerge 1,2,3 with no loss or duplication; imm_out stable while stalled.
- Flush with M and K both full and in_valid=1 that cycle → next cycle out_valid=0, in_ready=1. The flushed-cycle input is never output.
- Async reset asserted mid-stall (between clock edges) → out_valid=0, imm_out=0, in_ready=1 immediately, before the next edge.
- XLEN=64: op=101 with instr=0x800000B7 → 0xFFFFFFFF80000000. Op=010 with instr=0x7FF00093 → 0x00000000000007FF.

Source files
------------

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: valid/ready bundle for the immediate generator.
// Carries flush, the instr/ext_op/tag input side and the imm/tag/op output side.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [2:0]       ext_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm_out;
  logic [TAG_W-1:0] out_tag;
  logic [2:0]       out_op;

  modport master (
    output flush, in_valid, instr, ext_op,
    output in_tag, out_ready,
    input  in_ready, out_valid, imm_out,
    input  out_tag, out_op
  );

  modport slave (
    input  flush, in_valid, instr, ext_op,
    input  in_tag, out_ready,
    output in_ready, out_valid, imm_out,
    output out_tag, out_op
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV32I/RV64I immediate generator with skid buffer.
// Ports: clk, rst (async high), bus (slave: flush, in/out valid-ready, imm, tag, op).
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input logic           clk,
  input logic           rst,
  imm_gen_pipe_if.slave bus
);
  localparam int SHAMT_W = (XLEN == 32) ? 5 : 6;

  logic [31:7]      i;
  logic [XLEN-1:0]  imm_c;

  logic             mv, kv, rdy;
  logic [XLEN-1:0]  m_imm, k_imm;
  logic [TAG_W-1:0] m_tag, k_tag;
  logic [2:0]       m_op, k_op;
  logic             accept, drain;

  assign i = bus.instr[31:7];

  always_comb begin
    imm_c = '0;
    unique case (bus.ext_op)
      3'b000: imm_c = '0;
      3'b001: imm_c = XLEN'($signed({i[31:25], i[11:7]}));
      3'b010: imm_c = XLEN'($signed(i[31:20]));
      3'b011: imm_c = XLEN'(i[20+SHAMT_W-1:20]);
      3'b100: imm_c = XLEN'($signed({i[31], i[7], i[30:25],
                                     i[11:8], 1'b0}));
      3'b101: imm_c = XLEN'($signed({i[31:12], 12'b0}));
      3'b110: imm_c = XLEN'($signed({i[31], i[19:12], i[20],
                                     i[30:21], 1'b0}));
      3'b111: imm_c = XLEN'(i[19:15]);
    endcase
  end

  assign accept = bus.in_valid && rdy;
  assign drain  = mv && bus.out_ready;

  // rdy mirrors !kv but is its own flop so in_ready has no
  // combinational path from anything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mv    <= 1'b0;
      kv    <= 1'b0;
      rdy   <= 1'b1;
      m_imm <= '0;
      m_tag <= '0;
      m_op  <= '0;
      k_imm <= '0;
      k_tag <= '0;
      k_op  <= '0;
    end else if (bus.flush) begin
      mv  <= 1'b0;
      kv  <= 1'b0;
      rdy <= 1'b1;
    end else if (kv) begin
      if (drain) begin
        m_imm <= k_imm;
        m_tag <= k_tag;
        m_op  <= k_op;
        kv    <= 1'b0;
        rdy   <= 1'b1;
      end
    end else if (accept && (!mv || drain)) begin
      m_imm <= imm_c;
      m_tag <= bus.in_tag;
      m_op  <= bus.ext_op;
      mv    <= 1'b1;
    end else if (accept) begin
      k_imm <= imm_c;
      k_tag <= bus.in_tag;
      k_op  <= bus.ext_op;
      kv    <= 1'b1;
      rdy   <= 1'b0;
    end else if (drain) begin
      mv <= 1'b0;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = mv;
  assign bus.imm_out   = m_imm;
  assign bus.out_tag   = m_tag;
  assign bus.out_op    = m_op;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench driving XLEN=32 and XLEN=64 copies
// with identical stimulus; expectations come from an arithmetic model.
module tb_imm_gen_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) b64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .rst(rst), .bus(b32.slave));
  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .rst(rst), .bus(b64.slave));

  logic        tv, tfl, tordy;
  logic [31:0] tinstr;
  logic [2:0]  top;
  logic [4:0]  ttag;
  logic [63:0] cur_e32, cur_e64;

  assign b32.in_valid  = tv;
  assign b32.flush     = tfl;
  assign b32.out_ready = tordy;
  assign b32.instr     = tinstr;
  assign b32.ext_op    = top;
  assign b32.in_tag    = ttag;
  assign b64.in_valid  = tv;
  assign b64.flush     = tfl;
  assign b64.out_ready = tordy;
  assign b64.instr     = tinstr;
  assign b64.ext_op    = top;
  assign b64.in_tag    = ttag;

  typedef struct {
    logic [63:0] e32;
    logic [63:0] e64;
    logic [4:0]  tag;
    logic [2:0]  op;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint sx(longint v, int b);
    if (v >= (longint'(1) << (b - 1))) return v - (longint'(1) << b);
    return v;
  endfunction

  function automatic logic [63:0] ref_imm(logic [31:0] ins,
                                          logic [2:0] op, int xl);
    longint w, v;
    w = longint'(ins);
    case (op)
      3'd0: v = 0;
      3'd1: v = sx(((w >> 25) << 5) | ((w >> 7) & 31), 12);
      3'd2: v = sx(w >> 20, 12);
      3'd3: v = (w >> 20) & ((xl == 32) ? 31 : 63);
      3'd4: v = sx((((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) |
                   (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1), 13);
      3'd5: v = sx((w >> 12) << 12, 32);
      3'd6: v = sx((((w >> 31) & 1) << 20) | (((w >> 12) & 255) << 12) |
                   (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1), 21);
      default: v = (w >> 15) & 31;
    endcase
    if (xl == 32) return 64'(v) & 64'hFFFF_FFFF;
    return 64'(v);
  endfunction

  // Monitor: mid-cycle, compare presented entry and occupancy flags,
  // then apply what the coming edge will do to the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
    end else begin
      chk("in_ready32", 64'(b32.in_ready), 64'(sb.size() < 2));
      chk("in_ready64", 64'(b64.in_ready), 64'(sb.size() < 2));
      chk("out_valid32", 64'(b32.out_valid), 64'(sb.size() > 0));
      chk("out_valid64", 64'(b64.out_valid), 64'(sb.size() > 0));
      if (sb.size() > 0 && b32.out_valid) begin
        chk("imm32", 64'(b32.imm_out), {32'b0, sb[0].e32[31:0]});
        chk("tag32", 64'(b32.out_tag), 64'(sb[0].tag));
        chk("op32", 64'(b32.out_op), 64'(sb[0].op));
      end
      if (sb.size() > 0 && b64.out_valid) begin
        chk("imm64", b64.imm_out, sb[0].e64);
        chk("tag64", 64'(b64.out_tag), 64'(sb[0].tag));
      end
      if (tfl) begin
        sb.delete();
      end else begin
        if (b32.out_valid && tordy && sb.size() > 0) void'(sb.pop_front());
        if (tv && b32.in_ready) begin
          e.e32 = cur_e32;
          e.e64 = cur_e64;
          e.tag = ttag;
          e.op  = top;
          sb.push_back(e);
        end
      end
    end
  end

  task automatic idle(int n);
    tv = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Hold the input valid until a mid-cycle in_ready confirms acceptance.
  task automatic send(logic [31:0] ins, logic [2:0] op, logic [4:0] tg,
                      logic [63:0] e32, logic [63:0] e64);
    logic acc;
    int n;
    tv = 1'b1;
    tinstr = ins;
    top = op;
    ttag = tg;
    cur_e32 = e32;
    cur_e64 = e64;
    n = 0;
    do begin
      @(negedge clk);
      acc = b32.in_ready;
      @(posedge clk);
      #2;
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", 64'(acc), 64'd1);
  endtask

  logic [31:0] d_in [11] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3,
    32'h123450B7, 32'h001000EF, 32'h01F0D093, 32'h03F0D093, 32'h3401D0F3,
    32'h800000B7, 32'h7FF00093, 32'hFFFFFFFF};
  logic [2:0] d_op [11] = '{3'd2, 3'd1, 3'd4, 3'd5, 3'd6, 3'd3, 3'd3,
    3'd7, 3'd5, 3'd2, 3'd0};
  logic [63:0] d_e32 [11] = '{64'hFFFFFFFF, 64'hFFFFFFFC, 64'hFFFFFFF8,
    64'h12345000, 64'h800, 64'h1F, 64'h1F, 64'h3, 64'h80000000,
    64'h7FF, 64'h0};
  logic [63:0] d_e64 [11] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC,
    64'hFFFFFFFFFFFFFFF8, 64'h12345000, 64'h800, 64'h1F, 64'h3F, 64'h3,
    64'hFFFFFFFF80000000, 64'h7FF, 64'h0};

  initial begin
    rst = 1'b1;
    tv = 1'b0;
    tfl = 1'b0;
    tordy = 1'b1;
    tinstr = '0;
    top = '0;
    ttag = '0;
    cur_e32 = '0;
    cur_e64 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
    chk("rst_in_ready", 64'(b32.in_ready), 64'd1);
    chk("rst_imm64", b64.imm_out, 64'd0);
    chk("rst_tag", 64'(b32.out_tag), 64'd0);
    chk("rst_op", 64'(b64.out_op), 64'd0);
    #1 rst = 1'b0;
    idle(2);

    // Directed stream at full throughput
    for (int k = 0; k < 11; k++)
      send(d_in[k], d_op[k], 5'(k + 1), d_e32[k], d_e64[k]);
    idle(3);

    // Backpressure: tags 1 and 2 captured, 3 held upstream
    tordy = 1'b0;
    send(32'hFFF00093, 3'd2, 5'd1, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    send(32'h123450B7, 3'd5, 5'd2, 64'h12345000, 64'h12345000);
    tv = 1'b1;
    tinstr = 32'h001000EF;
    top = 3'd6;
    ttag = 5'd3;
    cur_e32 = 64'h800;
    cur_e64 = 64'h800;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(b32.in_ready), 64'd0);
      chk("bp_head_tag", 64'(b32.out_tag), 64'd1);
      chk("bp_head_imm", 64'(b32.imm_out), 64'hFFFFFFFF);
    end
    @(posedge clk);
    #2 tordy = 1'b1;
    send(32'h001000EF, 3'd6, 5'd3, 64'h800, 64'h800);
    idle(4);

    // Flush with M and K full and a valid input in the same cycle
    tordy = 1'b0;
    send(32'h7FF00093, 3'd2, 5'd4, 64'h7FF, 64'h7FF);
    send(32'h3401D0F3, 3'd7, 5'd5, 64'h3, 64'h3);
    tv = 1'b1;
    tinstr = 32'hFE112E23;
    top = 3'd1;
    ttag = 5'd6;
    tfl = 1'b1;
    @(posedge clk);
    #2;
    tfl = 1'b0;
    tv = 1'b0;
    tordy = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", 64'(b32.out_valid), 64'd0);
    chk("flush_in_ready", 64'(b64.in_ready), 64'd1);
    idle(3);

    // Async reset in the middle of a stall
    tordy = 1'b0;
    send(32'hFFF00093, 3'd2, 5'd7, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    send(32'h800000B7, 3'd5, 5'd8, 64'h80000000, 64'hFFFFFFFF80000000);
    tv = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(b32.out_valid), 64'd0);
    chk("arst_imm32", 64'(b32.imm_out), 64'd0);
    chk("arst_imm64", b64.imm_out, 64'd0);
    chk("arst_in_ready", 64'(b64.in_ready), 64'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    tordy = 1'b1;
    idle(2);

    // Randomized traffic
    for (int c = 0; c < 500; c++) begin
      tv = 1'($urandom_range(0, 1));
      tinstr = $urandom;
      top = 3'($urandom_range(0, 7));
      ttag = 5'($urandom_range(0, 31));
      tordy = ($urandom_range(0, 3) != 0);
      tfl = ($urandom_range(0, 40) == 0);
      cur_e32 = ref_imm(tinstr, top, 32);
      cur_e64 = ref_imm(tinstr, top, 64);
      @(posedge clk);
      #2;
    end
    tfl = 1'b0;
    tordy = 1'b1;
    idle(5);
    chk("drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
